// File: rtl/fmul_result_stage.sv
// fmul_result_stage: registered result stage behind the combinational FP multiplier.
// Recomputes the product exponent, applies IEEE special-case fixups for single and
// half precision, and presents results through a 2-entry skid buffer with sticky flags.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// the producer holds its data stable while valid is high and ready is low.
module fmul_result_stage #(
    parameter logic [31:0] NAN32 = 32'h7FC0_0000,
    parameter logic [15:0] NAN16 = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fpa,
    input  logic [31:0] fpb,
    input  logic [31:0] mul_raw,
    input  logic        mul_norm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_nan,
    input  logic        flag_clr
);

    logic        skid_valid;
    logic [31:0] skid_data;

    logic        half_mode;
    logic        sign;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [7:0]  exp_max;
    logic        man_a_nz;
    logic        man_b_nz;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [10:0] e_sum;
    logic signed [10:0] e_max_s;
    logic [31:0] fix_result;
    logic        fix_nan;
    logic        fix_ovf;
    logic        fix_unf;

    logic accept;
    logic out_fire;

    // The top bits of the raw word carry the multiplier's own sign/exponent, which are recomputed here.
    logic unused_raw_bits;
    assign unused_raw_bits = ^mul_raw[31:23];

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Decode operand fields and compute the fixed-up result for the current input.
    always_comb begin
        half_mode  = (fpa[31:16] == 16'h0) && (fpb[31:16] == 16'h0);
        sign       = half_mode ? (fpa[15] ^ fpb[15]) : (fpa[31] ^ fpb[31]);
        exp_a      = half_mode ? {3'b000, fpa[14:10]} : fpa[30:23];
        exp_b      = half_mode ? {3'b000, fpb[14:10]} : fpb[30:23];
        man_a_nz   = half_mode ? (|fpa[9:0]) : (|fpa[22:0]);
        man_b_nz   = half_mode ? (|fpb[9:0]) : (|fpb[22:0]);
        exp_max    = half_mode ? 8'd31 : 8'd255;
        a_nan      = (exp_a == exp_max) && man_a_nz;
        b_nan      = (exp_b == exp_max) && man_b_nz;
        a_inf      = (exp_a == exp_max) && !man_a_nz;
        b_inf      = (exp_b == exp_max) && !man_b_nz;
        // Denormals are flushed: any zero exponent counts as zero.
        a_zero     = (exp_a == 8'd0);
        b_zero     = (exp_b == 8'd0);
        e_max_s    = $signed({3'b000, exp_max});
        e_sum      = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b})
                   - (half_mode ? 11'sd15 : 11'sd127)
                   + $signed({10'b0, mul_norm});
        fix_result = 32'h0;
        fix_nan    = 1'b0;
        fix_ovf    = 1'b0;
        fix_unf    = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            fix_result = half_mode ? {16'h0, NAN16} : NAN32;
            fix_nan    = 1'b1;
        end else if (a_inf || b_inf) begin
            fix_result = half_mode ? {16'h0, sign, 5'h1F, 10'h0} : {sign, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            fix_result = half_mode ? {16'h0, sign, 15'h0} : {sign, 31'h0};
        end else if (e_sum >= e_max_s) begin
            fix_result = half_mode ? {16'h0, sign, 5'h1F, 10'h0} : {sign, 8'hFF, 23'h0};
            fix_ovf    = 1'b1;
        end else if (e_sum <= 11'sd0) begin
            fix_result = half_mode ? {16'h0, sign, 15'h0} : {sign, 31'h0};
            fix_unf    = 1'b1;
        end else begin
            fix_result = half_mode ? {16'h0, sign, e_sum[4:0], mul_raw[9:0]}
                                   : {sign, e_sum[7:0], mul_raw[22:0]};
        end
    end

    // Output register plus skid entry: the skid only fills while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 32'h0;
            skid_valid <= 1'b0;
            skid_data  <= 32'h0;
        end else if (out_fire || !out_valid) begin
            if (skid_valid) begin
                // in_ready is low whenever the skid is full, so no accept can coincide here.
                out_valid  <= 1'b1;
                out_result <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_result <= fix_result;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= fix_result;
        end
    end

    // Sticky exception flags; a clear in the same cycle beats a new set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_nan <= 1'b0;
        end else if (flag_clr) begin
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_nan <= 1'b0;
        end else if (accept) begin
            flag_ovf <= flag_ovf | fix_ovf;
            flag_unf <= flag_unf | fix_unf;
            flag_nan <= flag_nan | fix_nan;
        end
    end

endmodule

// File: tb/tb_fmul_result_stage.sv
// Bench for fmul_result_stage: directed cases plus randomized traffic checked
// against an arithmetic reference model and an in-order expected queue.
module tb_fmul_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fpa;
    logic [31:0] fpb;
    logic [31:0] mul_raw;
    logic        mul_norm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_nan;
    logic        flag_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    bit m_ovf = 0;
    bit m_unf = 0;
    bit m_nan = 0;
    bit last_acc = 0;

    fmul_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fpa        (fpa),
        .fpb        (fpb),
        .mul_raw    (mul_raw),
        .mul_norm   (mul_norm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .flag_ovf   (flag_ovf),
        .flag_unf   (flag_unf),
        .flag_nan   (flag_nan),
        .flag_clr   (flag_clr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: decode by field widths, multiply magnitudes via exponent arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] raw, input bit norm,
                                            output bit nan, output bit ovf, output bit unf);
        bit half;
        int mb, eb, emax, bias, w, ea, eb_v, e;
        bit sa, sb, sign, ma_nz, mb_nz;
        logic [31:0] sbit, mmask;
        half = (a[31:16] == 0) && (b[31:16] == 0);
        mb   = half ? 10 : 23;
        eb   = half ? 5 : 8;
        w    = half ? 16 : 32;
        emax = (1 << eb) - 1;
        bias = half ? 15 : 127;
        mmask = (32'd1 << mb) - 1;
        sa   = a[w-1];
        sb   = b[w-1];
        sign = sa ^ sb;
        sbit = sign ? (32'd1 << (w - 1)) : 32'd0;
        ea   = int'((a >> mb) & emax);
        eb_v = int'((b >> mb) & emax);
        ma_nz = (a & mmask) != 0;
        mb_nz = (b & mmask) != 0;
        nan = 0; ovf = 0; unf = 0;
        if ((ea == emax && ma_nz) || (eb_v == emax && mb_nz) ||
            (ea == emax && eb_v == 0) || (eb_v == emax && ea == 0)) begin
            nan = 1;
            return half ? 32'h0000_7E00 : 32'h7FC0_0000;
        end
        if (ea == emax || eb_v == emax) return sbit | (32'(emax) << mb);
        if (ea == 0 || eb_v == 0) return sbit;
        e = ea + eb_v - bias + int'(norm);
        if (e >= emax) begin
            ovf = 1;
            return sbit | (32'(emax) << mb);
        end
        if (e <= 0) begin
            unf = 1;
            return sbit;
        end
        return sbit | (32'(e) << mb) | (raw & mmask);
    endfunction

    function automatic logic [31:0] rand_fp(input bit half);
        int k;
        logic [7:0]  e;
        logic [22:0] m;
        bit s;
        k = $urandom_range(0, 9);
        s = 1'($urandom_range(0, 1));
        m = ($urandom_range(0, 2) == 0) ? 23'h0 : 23'($urandom);
        case (k)
            0: e = 8'd0;
            1: e = half ? 8'd31 : 8'd255;
            2: e = 8'd1;
            3: e = half ? 8'd30 : 8'd254;
            default: e = half ? 8'($urandom_range(8, 22)) : 8'($urandom_range(100, 154));
        endcase
        return half ? {16'h0, s, e[4:0], m[9:0]} : {s, e, m};
    endfunction

    // Driver: new random operand set
    task automatic rand_ops();
        bit half;
        half     = ($urandom_range(0, 2) == 0);
        fpa      = rand_fp(half);
        fpb      = rand_fp(half);
        mul_raw  = $urandom;
        mul_norm = 1'($urandom_range(0, 1));
    endtask

    // One clock: check state at negedge against the model, then advance the model.
    task automatic cycle();
        logic [31:0] r;
        bit n, o, u, acc;
        int sz;
        @(negedge clk);
        sz = exp_q.size();
        check("out_valid", 32'(out_valid), 32'(sz > 0));
        check("in_ready", 32'(in_ready), 32'(sz < 2));
        check("flags", {29'h0, flag_ovf, flag_unf, flag_nan}, {29'h0, m_ovf, m_unf, m_nan});
        if (sz > 0 && out_ready && !rst) check("out_result", out_result, exp_q.pop_front());
        acc = in_valid && !rst && (sz < 2);
        last_acc = acc;
        n = 0; o = 0; u = 0;
        if (acc) begin
            r = ref_mul(fpa, fpb, mul_raw, mul_norm, n, o, u);
            exp_q.push_back(r);
        end
        if (!rst) begin
            if (flag_clr) begin
                m_ovf = 0; m_unf = 0; m_nan = 0;
            end else begin
                m_ovf |= o; m_unf |= u; m_nan |= n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] raw, input bit norm, input logic [31:0] exp);
        fpa = a; fpb = b; mul_raw = raw; mul_norm = norm;
        in_valid = 1; out_ready = 1; flag_clr = 0;
        cycle();
        check(tag, out_result, exp);
        in_valid = 0;
        cycle();
    endtask

    initial begin
        rst = 1; in_valid = 0; fpa = 0; fpb = 0; mul_raw = 0; mul_norm = 0;
        out_ready = 1; flag_clr = 0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", {29'h0, flag_ovf, flag_unf, flag_nan}, 32'h0);
        @(posedge clk); #1;
        rst = 0;

        // T1 single normal
        directed("t1_normal", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 32'h40C0_0000);
        // T2 overflow and flag clear
        directed("t2_ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h0, 0, 32'h7F80_0000);
        check("t2_flag_ovf", 32'(flag_ovf), 32'd1);
        flag_clr = 1; cycle(); flag_clr = 0;
        check("t2_flag_clr", 32'(flag_ovf), 32'd0);
        // T3 specials
        directed("t3_negzero", 32'h0000_0000, 32'hC000_0000, 32'h0, 0, 32'h8000_0000);
        directed("t3_nan", 32'h7F80_0000, 32'h0000_0000, 32'h0, 0, 32'h7FC0_0000);
        check("t3_flag_nan", 32'(flag_nan), 32'd1);
        directed("t3_unf", 32'h0080_0000, 32'h0080_0000, 32'h0, 0, 32'h0000_0000);
        check("t3_flag_unf", 32'(flag_unf), 32'd1);
        // T4 half mode
        directed("t4_half", 32'h0000_4000, 32'h0000_4200, 32'h0000_4600, 0, 32'h0000_4600);
        directed("t4_half_nan", 32'h0000_7C00, 32'h0000_0000, 32'h0, 0, 32'h0000_7E00);
        directed("t4_norm", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1, 32'h4010_0000);

        // T5 backpressure: three back-to-back offers with the consumer stalled
        out_ready = 0; in_valid = 1;
        fpa = 32'h4000_0000; fpb = 32'h4000_0000; mul_raw = 32'h0011_1111; mul_norm = 0; cycle();
        fpa = 32'h4040_0000; fpb = 32'h3F80_0000; mul_raw = 32'h0022_2222; mul_norm = 1; cycle();
        fpa = 32'h0000_3C00; fpb = 32'h0000_4000; mul_raw = 32'h0000_0155; mul_norm = 0;
        check("t5_in_ready", 32'(in_ready), 32'd0);
        cycle();
        out_ready = 1;
        cycle();
        cycle();
        in_valid = 0;
        cycle(); cycle();

        // T6 reset with output and skid both occupied
        out_ready = 0; in_valid = 1;
        fpa = 32'h7F00_0000; fpb = 32'h7F00_0000; mul_raw = 0; mul_norm = 0; cycle();
        fpa = 32'h4000_0000; fpb = 32'h4000_0000; cycle();
        in_valid = 0;
        check("t6_full", 32'(in_ready), 32'd0);
        #2 rst = 1;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_flags", {29'h0, flag_ovf, flag_unf, flag_nan}, 32'h0);
        exp_q.delete();
        m_ovf = 0; m_unf = 0; m_nan = 0;
        cycle();
        rst = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic with random backpressure and occasional flag clears
        in_valid = 0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_ops();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flag_clr  = ($urandom_range(0, 15) == 0);
            cycle();
        end
        in_valid = 0; out_ready = 1; flag_clr = 0;
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
